// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the pipelined MIPS core.
// Fetch entries pair each instruction word with the PC it was fetched from.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t FETCH_PC_STEP = 32'd4;

    function automatic word_t align_word(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous FIFO with flush; any DEPTH >= 2, not only powers of two.
// Flush has priority over push and pop. A pop on an empty queue does nothing.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = fetch_entry_t,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic          i_flush,
    input  T              i_data,
    output T              o_data,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_do_push;
    logic          w_do_pop;
    logic [PW-1:0] w_rd_next;
    logic [PW-1:0] w_wr_next;

    always_comb begin
        o_full    = (r_count == CW'(DEPTH));
        o_empty   = (r_count == '0);
        w_do_pop  = i_pop && !o_empty;
        // A full queue still accepts a push when the head leaves in the same cycle.
        w_do_push = i_push && (!o_full || w_do_pop);
        w_rd_next = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
        w_wr_next = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
        o_data    = r_mem[r_rd_ptr];
        o_count   = r_count;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= w_wr_next;
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && !i_flush && w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues icache reads and buffers
// {pc, instr} pairs so decode stalls do not stall the icache. Redirect beats everything.
module fetch_queue_unit
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT = 32'h0,
    parameter int unsigned DEPTH   = 4,
    parameter word_t       PC_STEP = FETCH_PC_STEP
) (
    input  logic  CLK,
    input  logic  nRST,
    output logic  imemREN,
    output word_t imemaddr,
    input  logic  ihit,
    input  word_t imemload,
    input  logic  redirect,
    input  word_t redirect_pc,
    input  logic  halt,
    input  logic  deq_ready,
    output logic  deq_valid,
    output word_t deq_instr,
    output word_t deq_pc,
    output word_t deq_npc,
    output logic  halted
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    word_t         r_pc;
    logic          r_halted;

    logic          w_space;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_wr_entry;
    fetch_entry_t  w_head;

    always_comb begin
        deq_valid  = nRST && !w_empty;
        w_space    = (w_count < CW'(DEPTH)) || (deq_valid && deq_ready);
        imemREN    = nRST && w_space && !r_halted && !halt && !redirect;
        imemaddr   = r_pc;
        w_push     = imemREN && ihit;
        // A redirect discards the same-cycle pop along with the rest of the queue.
        w_pop      = deq_valid && deq_ready && !redirect;
        w_wr_entry = '{pc: r_pc, instr: imemload};
        deq_pc     = w_head.pc;
        deq_instr  = w_head.instr;
        deq_npc    = w_head.pc + PC_STEP;
        halted     = r_halted;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_pc     <= PC_INIT;
            r_halted <= 1'b0;
        end else begin
            if (redirect) begin
                r_pc <= align_word(redirect_pc);
            end else if (w_push) begin
                r_pc <= r_pc + PC_STEP;
            end
            if (halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (nRST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_data  (w_wr_entry),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (nRST) begin
            assert (!(w_push && w_full && !w_pop));
            assert (imemaddr[1:0] == 2'b00);
        end
    end

endmodule
